// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK bits per cycle, LSB chunk first, over N = WIDTH/CHUNK cycles.
// Latency: start accepted in cycle 0, busy in cycles 1..N, done pulse and result in cycle N+1.
// Flow control: start is ignored while busy; optional subtract mode with macro CHUNKED_ADDER_SUB_EN.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_q, b_q, acc, full;
    logic              carry;
    logic [31:0]       base;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [CHUNK:0]    csum;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              accept, last;

    // Subtraction is folded into the operands at capture time, so the
    // datapath only ever adds; overflow then naturally uses the inverted b.
`ifdef CHUNKED_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign busy   = (state == RUN);
    assign accept = (state == IDLE) && start;
    assign last   = (cnt == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: leave IDLE on start, return after the last chunk.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current chunk add, and the partial-sum word with this chunk merged in.
    always_comb begin
        base    = 32'(cnt) * 32'(CHUNK);
        a_chunk = CHUNK'(a_q >> base);
        b_chunk = CHUNK'(b_q >> base);
        csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        full    = (acc & ~(MASK << base)) | (WIDTH'(csum[CHUNK-1:0]) << base);
    end

    // Operand capture, chunk sequencing and result registers; outputs only
    // change on the final chunk so they hold the previous result during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q   <= a;
                b_q   <= b_eff;
                carry <= cin_eff;
                cnt   <= '0;
                acc   <= '0;
            end else if (busy) begin
                acc   <= full;
                carry <= csum[CHUNK];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    s        <= full;
                    cout     <= csum[CHUNK];
                    // Same-sign operands giving an opposite-sign sum is exactly
                    // carry-into-MSB XOR carry-out-of-MSB.
                    overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (full[WIDTH-1] != a_q[WIDTH-1]);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits (>=1).
REQ-002 The block SHALL have parameter CHUNK, default 4, bits added per cycle (1..WIDTH, WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to begin an addition, sampled each rising edge.
REQ-006 The block SHALL have ports a, b  input  WIDTH  operands, captured when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 The block SHALL have port s  output  WIDTH  sum, registered.
REQ-009 The block SHALL have port cout  output  1  carry-out of bit WIDTH-1, registered.
REQ-010 The block SHALL have port overflow  output  1  two's-complement signed overflow, registered.
REQ-011 The block SHALL have port busy  output  1  high while chunks are being processed.
REQ-012 The block SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-013 States SHALL be IDLE and RUN; start is accepted only in IDLE (busy=0).
REQ-014 On an accepted start in cycle 0, a, b, cin SHALL be latched, chunk counter cleared, state -> RUN.
REQ-015 In RUN, cycle i (i=1..N) SHALL add chunk i-1 (LSB chunk first) of latched a, b plus the running carry, storing the CHUNK-bit partial sum internally.
REQ-016 busy SHALL be 1 in cycles 1..N exactly; state -> IDLE after cycle N.
REQ-017 In cycle N+1: s, cout, overflow SHALL present the complete result and done SHALL be 1 for that cycle only; latency start->done = N+1 cycles.
REQ-018 s, cout, overflow SHALL NOT change during RUN; they hold the previous result until the next completion.
REQ-019 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-020 Result SHALL equal (a + b + cin) mod 2^WIDTH, cout the bit WIDTH; no wider arithmetic leaks.
REQ-021 start while busy=1 SHALL be ignored, no effect on the running operation or latched operands.
REQ-022 start in the done cycle (busy=0) SHALL be accepted; back-to-back throughput one result per N+1 cycles.
REQ-023 With CHUNK=WIDTH (N=1), busy SHALL be high one cycle and done in cycle 2.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, counter 0, and s=0, cout=0, overflow=0, busy=0, done=0.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst overrides start in the same cycle.

Configuration
REQ-026 Macro CHUNKED_ADDER_SUB_EN SHALL, when defined, add port sub  input  1, captured with start; sub=1 computes a + ~b + 1 (cin ignored), cout=1 meaning no borrow, overflow per REQ-019 on the inverted operand.
REQ-027 Without CHUNKED_ADDER_SUB_EN, port sub SHALL not exist and the block SHALL add only.

Verification
REQ-028 WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, start at cycle 0 -> busy cycles 1..4, done cycle 5, s=0x0000, cout=1, overflow=0.
REQ-029 WIDTH=16, CHUNK=4: a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, cout=0, overflow=1.
REQ-030 WIDTH=1, CHUNK=1: all 8 (a,b,cin) combinations -> s/cout match full-adder truth table, done cycle 2 each.
REQ-031 start with a=0x1234, b=0x1111 then start with a=0xFFFF at cycle 2 -> second ignored, s=0x2345 at cycle 5; start in cycle 5 accepted.
REQ-032 rst at cycle 3 of a RUN -> no done pulse, all outputs 0 from cycle 4.
REQ-033 With CHUNKED_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0, overflow=0.
